// File: rtl/anyedge_pkg.sv
// Shared types and helpers for the delayed any-edge handshake checker.
package anyedge_pkg;

  typedef enum logic [2:0] {PRIME, IDLE, SETTLE, HOLD, DONE} state_t;

  // Timer must hold the larger of the two countdown loads.
  function automatic int timer_w(input int settle, input int hold);
    int m;
    m = (settle > hold) ? settle : hold;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  // Saturating add clamped at 2^w-1 (w <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] val,
                                          input logic [1:0]  inc,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    lim = (w >= 32) ? 33'h0_FFFF_FFFF : ((33'd1 << w) - 33'd1);
    sum = {1'b0, val} + {31'b0, inc};
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/anyedge_det.sv
// Any-edge detector: a_q tracks sig every cycle, hit is suppressed until
// a_q has been loaded once after reset.
module anyedge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic hit
);

  logic a_q;
  logic primed;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= 1'b0;
      primed <= 1'b0;
    end else begin
      a_q    <= sig;
      primed <= 1'b1;
    end
  end

  assign hit = primed & (sig ^ a_q);

endmodule

// File: rtl/anyedge_resp_checker.sv
// Responder/checker for the two-flag delayed any-edge handshake: checks
// flag_b low at the request edge and high SETTLE_CYC cycles later.
module anyedge_resp_checker
  import anyedge_pkg::*;
#(
  parameter int SETTLE_CYC = 3,
  parameter int HOLD_CYC   = 6,
  parameter int END_AFTER  = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flag_a,
  input  logic             flag_b,
  output logic             busy,
  output logic             chk_pass,
  output logic             err_early,
  output logic             err_late,
  output logic             err_overlap,
  output logic             done,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int            TW       = timer_w(SETTLE_CYC, HOLD_CYC);
  localparam logic [TW-1:0] T_SETTLE = TW'(SETTLE_CYC);
  localparam logic [TW-1:0] T_HOLD   = TW'(HOLD_CYC);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [31:0]   N_END    = 32'(END_AFTER);

  state_t      state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic        early_seen, early_seen_nx;
  logic [31:0] txn_cnt, txn_nx;
  logic        hit;
  logic        accept, early_nx, late_nx, pass_nx, ovl_nx, rearm;
  logic [1:0]  nerr;

  anyedge_det u_det (
    .clk (clk),
    .rst (rst),
    .sig (flag_a),
    .hit (hit)
  );

  always_comb begin
    state_nx      = state;
    timer_nx      = timer;
    early_seen_nx = early_seen;
    txn_nx        = txn_cnt;
    accept        = 1'b0;
    early_nx      = 1'b0;
    late_nx       = 1'b0;
    pass_nx       = 1'b0;
    ovl_nx        = 1'b0;
    rearm         = 1'b0;
    case (state)
      PRIME: state_nx = IDLE;
      IDLE: begin
        if (hit) begin
          accept        = 1'b1;
          early_nx      = flag_b;
          early_seen_nx = flag_b;
          timer_nx      = T_SETTLE;
          state_nx      = SETTLE;
        end
      end
      SETTLE: begin
        ovl_nx = hit;
        if (timer == T_ONE) begin
          late_nx = ~flag_b;
          pass_nx = flag_b & ~early_seen;
          // Completed count only needs to reach END_AFTER, so it stops there.
          if (txn_cnt < N_END) txn_nx = txn_cnt + 32'd1;
          if (HOLD_CYC == 0) begin
            rearm = 1'b1;
          end else begin
            timer_nx = T_HOLD;
            state_nx = HOLD;
          end
        end else begin
          timer_nx = timer - T_ONE;
        end
      end
      HOLD: begin
        ovl_nx = hit;
        if (timer == T_ONE) rearm = 1'b1;
        else                timer_nx = timer - T_ONE;
      end
      DONE: ;
      default: state_nx = PRIME;
    endcase
    if (rearm)
      state_nx = (END_AFTER != 0 && txn_nx == N_END) ? DONE : IDLE;
    nerr = {1'b0, early_nx} + {1'b0, late_nx} + {1'b0, ovl_nx};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PRIME;
      timer       <= '0;
      early_seen  <= 1'b0;
      txn_cnt     <= '0;
      busy        <= 1'b0;
      chk_pass    <= 1'b0;
      err_early   <= 1'b0;
      err_late    <= 1'b0;
      err_overlap <= 1'b0;
      done        <= 1'b0;
      edge_cnt    <= '0;
      err_cnt     <= '0;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      early_seen  <= early_seen_nx;
      txn_cnt     <= txn_nx;
      busy        <= (state_nx == SETTLE) || (state_nx == HOLD);
      chk_pass    <= pass_nx;
      err_early   <= early_nx;
      err_late    <= late_nx;
      err_overlap <= ovl_nx;
      done        <= done | (state_nx == DONE);
      if (accept)
        edge_cnt <= CNT_W'(sat_add(32'(edge_cnt), 2'd1, CNT_W));
      err_cnt <= CNT_W'(sat_add(32'(err_cnt), nerr, CNT_W));
    end
  end

endmodule
